// File: rtl/mmu_seq_pkg.sv
// mmu_seq_pkg
// Shared definitions for the MMU tile sequencer: FSM state type and encodings,
// plus default parameter values for the sequencer and its watchdog.
// The state type is 3 bits wide so the ERR state used by the optional
// watchdog build (MMU_SEQ_WATCHDOG_EN) always has an encoding.

package mmu_seq_pkg;

    localparam int unsigned TILE_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 64;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_FINISH = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StIssue  = ST_ISSUE,
        StWait   = ST_WAIT,
        StFinish = ST_FINISH,
        StErr    = ST_ERR
    } state_e;

endpackage

// File: rtl/mmu_seq_watchdog.sv
// mmu_seq_watchdog
// Per-tile wait counter. Counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th enabled cycle is in progress.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   clear   in   restart the count (one cycle before the first counted cycle)
//   enable  in   count this cycle
//   expired out  high during the TIMEOUT-th consecutive enabled cycle

module mmu_seq_watchdog
    import mmu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    // Count value seen during the TIMEOUT-th enabled cycle (first cycle sees 0).
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = enable && (r_cnt == LIMIT);

endmodule

// File: rtl/mmu_tile_sequencer.sv
// mmu_tile_sequencer
// Initiator side of the MMU start/done handshake. Accepts a job of N tiles,
// issues one start pulse per tile to a downstream start/done unit, waits for
// its done pulse, and pulses job_done_o once every tile has completed.
// Optional watchdog: define MMU_SEQ_WATCHDOG_EN to add a per-tile timeout
// that ends the job through an ERR state and sets the sticky err_o flag.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   job_valid_i  in   upstream offers a job
//   job_tiles_i  in   tile count of the offered job (0 legal)
//   job_ready_o  out  job can be accepted (IDLE only)
//   start_o      out  one-cycle start pulse per tile
//   done_i       in   one-cycle completion pulse from downstream
//   busy_o       out  any state other than IDLE
//   tile_idx_o   out  index of the tile being issued or awaited
//   job_done_o   out  one-cycle job completion pulse
//   err_o        out  sticky timeout flag (0 without the watchdog)

module mmu_tile_sequencer
    import mmu_seq_pkg::*;
#(
    parameter int unsigned TILE_W  = TILE_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid_i,
    input  logic [TILE_W-1:0] job_tiles_i,
    output logic              job_ready_o,
    output logic              start_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              job_done_o,
    output logic              err_o
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mmu_tile_sequencer: TIMEOUT must be at least 1");
    end

    state_e            r_state, w_state_d;
    logic [TILE_W-1:0] r_tiles, w_tiles_d;
    logic [TILE_W-1:0] r_tile_idx, w_tile_idx_d;
    // Set for the one turnaround cycle between a non-final done and the next
    // ISSUE; done_i is not sampled in that cycle.
    logic              r_adv, w_adv_d;

`ifdef MMU_SEQ_WATCHDOG_EN
    logic r_err, w_err_d;
    logic w_expired;

    mmu_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (r_state == StIssue),
        .enable  ((r_state == StWait) && !r_adv),
        .expired (w_expired)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_tiles    <= '0;
            r_tile_idx <= '0;
            r_adv      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_tiles    <= w_tiles_d;
            r_tile_idx <= w_tile_idx_d;
            r_adv      <= w_adv_d;
        end
    end

`ifdef MMU_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_d;
        end
    end
`endif

    always_comb begin
        w_state_d    = r_state;
        w_tiles_d    = r_tiles;
        w_tile_idx_d = r_tile_idx;
        w_adv_d      = 1'b0;
`ifdef MMU_SEQ_WATCHDOG_EN
        w_err_d      = r_err;
`endif
        case (r_state)
            StIdle: begin
                if (job_valid_i) begin
                    w_tiles_d    = job_tiles_i;
                    w_tile_idx_d = '0;
`ifdef MMU_SEQ_WATCHDOG_EN
                    w_err_d      = 1'b0;
`endif
                    w_state_d    = (job_tiles_i == '0) ? StFinish : StIssue;
                end
            end
            StIssue: begin
                w_state_d = StWait;
            end
            StWait: begin
                if (r_adv) begin
                    w_tile_idx_d = r_tile_idx + 1'b1;
                    w_state_d    = StIssue;
                end else if (done_i) begin
                    // r_tiles is non-zero here, so tiles-1 never underflows.
                    if (r_tile_idx == r_tiles - 1'b1) begin
                        w_state_d = StFinish;
                    end else begin
                        w_adv_d = 1'b1;
                    end
                end
`ifdef MMU_SEQ_WATCHDOG_EN
                else if (w_expired) begin
                    w_err_d   = 1'b1;
                    w_state_d = StErr;
                end
`endif
            end
            StFinish: begin
                w_state_d = StIdle;
            end
`ifdef MMU_SEQ_WATCHDOG_EN
            StErr: begin
                w_state_d = StIdle;
            end
`endif
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign job_ready_o = (r_state == StIdle);
    assign busy_o      = (r_state != StIdle);
    assign start_o     = (r_state == StIssue);
    assign job_done_o  = (r_state == StFinish) || (r_state == StErr);
    assign tile_idx_o  = r_tile_idx;

`ifdef MMU_SEQ_WATCHDOG_EN
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// tb_mmu_tile_sequencer
// Self-checking bench for mmu_tile_sequencer. A job-level timing model
// (start, done and job_done cycles derived from tile count and per-tile
// downstream latency) predicts every output cycle by cycle. Directed table
// vectors, random jobs and hand-written reset / watchdog sequences.

module tb_mmu_tile_sequencer;

    localparam int unsigned TILE_W  = 8;
    localparam int unsigned TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              job_valid_i = 1'b0;
    logic [TILE_W-1:0] job_tiles_i = '0;
    logic              job_ready_o;
    logic              start_o;
    logic              done_i = 1'b0;
    logic              busy_o;
    logic [TILE_W-1:0] tile_idx_o;
    logic              job_done_o;
    logic              err_o;

    mmu_tile_sequencer #(
        .TILE_W  (TILE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .job_valid_i (job_valid_i),
        .job_tiles_i (job_tiles_i),
        .job_ready_o (job_ready_o),
        .start_o     (start_o),
        .done_i      (done_i),
        .busy_o      (busy_o),
        .tile_idx_o  (tile_idx_o),
        .job_done_o  (job_done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-tile downstream latency: done_i arrives lat_a[k] cycles after start k.
    int lat_a [256];
    int starts[256];
    int dones [256];

    // Offers a job of n tiles, then checks every cycle through the IDLE return.
    // Entry and exit are at a falling edge. With hold set, job_valid_i stays
    // high (tiles = hold_tiles) so the next job can be taken back-to-back.
    task automatic run_job(input int n, input bit hold, input int hold_tiles, input bit spur,
                           output int seen_jd);
        int  s;
        int  jd;
        int  exp_k;
        bit  exp_start;
        bit  dn;
        s = 1;
        for (int k = 0; k < n; k++) begin
            starts[k] = s;
            dones[k]  = s + lat_a[k];
            s         = dones[k] + 2;
        end
        jd      = (n == 0) ? 1 : dones[n-1] + 1;
        seen_jd = -1;

        job_valid_i = 1'b1;
        job_tiles_i = n[TILE_W-1:0];
        done_i      = 1'b0;
        chk("ready_before_accept", job_ready_o, 1);
        @(posedge clk);
        for (int c = 1; c <= jd + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) job_tiles_i = hold_tiles[TILE_W-1:0];
                else      job_valid_i = 1'b0;
            end
            exp_start = 1'b0;
            exp_k     = 0;
            dn        = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (starts[k] == c) begin
                    exp_start = 1'b1;
                    exp_k     = k;
                end
                if (dones[k] == c) dn = 1'b1;
            end
            chk("start_o", start_o, exp_start);
            if (exp_start) chk("tile_idx_o", tile_idx_o, exp_k);
            chk("job_done_o", job_done_o, (c == jd));
            if (job_done_o && seen_jd < 0) seen_jd = c;
            chk("busy_o", busy_o, (c <= jd));
            chk("job_ready_o", job_ready_o, (c > jd));
            chk("err_o", err_o, 0);
            // Spurious done pulses land only on ISSUE or FINISH cycles.
            if (spur && !dn && (exp_start || c == jd) && $urandom_range(1) == 1) dn = 1'b1;
            done_i = (c <= jd) ? dn : 1'b0;
        end
    endtask

    typedef struct {
        int tiles;
        int lat;
        bit hold;
        int hold_tiles;
        int exp_jd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen;
        int n;

        vecs[0] = '{3, 3, 1'b0, 0, 15};    // COUNT_NUM = 2 model
        vecs[1] = '{0, 1, 1'b0, 0, 1};     // zero-tile job
        vecs[2] = '{1, 1, 1'b0, 0, 3};
        vecs[3] = '{2, 4, 1'b1, 5, 12};    // valid held with a different count
        vecs[4] = '{5, 2, 1'b0, 0, 20};    // the held job, taken back-to-back
        vecs[5] = '{255, 1, 1'b0, 0, 765}; // largest count, no index wrap

        // Reset state
        #2;
        chk("rst_ready", job_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_job_done", job_done_o, 0);
        chk("rst_tile_idx", tile_idx_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Spurious done pulses while idle
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("idle_start", start_o, 0);
            chk("idle_busy", busy_o, 0);
            chk("idle_ready", job_ready_o, 1);
            done_i = c[0];
        end
        @(negedge clk);
        done_i = 1'b0;

        // Directed table
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 256; k++) lat_a[k] = vecs[v].lat;
            run_job(vecs[v].tiles, vecs[v].hold, vecs[v].hold_tiles, 1'b1, seen);
            chk("job_done_cycle", seen, vecs[v].exp_jd);
        end

        // Random jobs with random per-tile latency and idle gaps
        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) lat_a[k] = $urandom_range(1, 4);
            run_job(n, 1'b0, 0, 1'b1, seen);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Async reset during WAIT of tile 1
        job_valid_i = 1'b1;
        job_tiles_i = 8'd3;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) job_valid_i = 1'b0;
            if (c == 6) begin
                chk("mid_start_tile1", start_o, 1);
                chk("mid_idx_tile1", tile_idx_o, 1);
            end
            done_i = (c == 4);
        end
        done_i = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_ready", job_ready_o, 1);
        chk("arst_busy", busy_o, 0);
        chk("arst_start", start_o, 0);
        chk("arst_job_done", job_done_o, 0);
        chk("arst_tile_idx", tile_idx_o, 0);
        chk("arst_err", err_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("post_rst_start", start_o, 0);
            chk("post_rst_busy", busy_o, 0);
            chk("post_rst_job_done", job_done_o, 0);
            done_i = (c == 1);
        end
        done_i = 1'b0;

`ifdef MMU_SEQ_WATCHDOG_EN
        // done_i never returns: 4 WAIT cycles, then ERR
        job_valid_i = 1'b1;
        job_tiles_i = 8'd1;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) job_valid_i = 1'b0;
            chk("wd_job_done", job_done_o, (c == 6));
            chk("wd_err", err_o, (c >= 6));
            chk("wd_start", start_o, (c == 1));
            if (c == 7) chk("wd_ready", job_ready_o, 1);
        end
        // New job clears err_o; done_i on the expiry cycle wins
        lat_a[0] = TIMEOUT;
        run_job(1, 1'b0, 0, 1'b0, seen);
        chk("wd_done_on_expiry", seen, TIMEOUT + 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
